// File: rtl/xadac_elastic.sv
// xadac_elastic: circular-FIFO elastic buffer on a valid/ready stream.
// Ready toward the producer depends only on registered occupancy, so the
// consumer's ready never reaches the producer combinationally. An optional
// fall-through path lets a beat cross an empty buffer in zero cycles.
module xadac_elastic #(
  parameter type         DataT       = logic,
  parameter int unsigned Depth       = 4,
  parameter bit          FallThrough = 1'b0,
  parameter int unsigned AlmostFull  = Depth - 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  DataT                       slv_data,
  input  logic                       slv_valid,
  output logic                       slv_ready,
  output DataT                       mst_data,
  output logic                       mst_valid,
  input  logic                       mst_ready,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] AfCnt    = CntW'(AlmostFull);

  DataT            r_mem [Depth];
  logic [PtrW-1:0] r_rptr;
  logic [PtrW-1:0] r_wptr;
  logic [CntW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_bypass;
  logic w_do_write;
  logic w_do_read;

  // Pointers wrap with an explicit compare so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DepthCnt);

  // Handshake outputs: ready from registered state, gated only by flush/reset.
  assign slv_ready = rstn && !flush && !w_full;
  assign mst_valid = !flush && (!w_empty || (FallThrough && slv_valid));
  assign mst_data  = (FallThrough && w_empty) ? slv_data : r_mem[r_rptr];

  assign w_push = slv_valid && slv_ready;
  assign w_pop  = mst_valid && mst_ready;

  // A beat that enters and leaves an empty buffer in one cycle never touches
  // storage, pointers or the count.
  assign w_bypass   = FallThrough && w_empty && w_push && w_pop;
  assign w_do_write = w_push && !w_bypass;
  assign w_do_read  = w_pop && !w_bypass;

  assign count       = r_count;
  assign almost_full = (r_count >= AfCnt);

  // Storage write port; flush and reset only move the pointers.
  // NOTE: the data array has no reset branch on purpose -- resetting it would
  // turn a plain RAM into a bank of resettable flops for no functional gain,
  // since an entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_wptr] <= slv_data;
    end
  end

  // Read/write pointer update with synchronous reset and flush.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      if (w_do_write) r_wptr <= ptr_inc(r_wptr);
      if (w_do_read)  r_rptr <= ptr_inc(r_rptr);
    end
  end

  // Occupancy: +1 on a stored push, -1 on a stored pop, unchanged on both.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_count <= '0;
    end else if (w_do_write && !w_do_read) begin
      r_count <= r_count + 1'b1;
    end else if (!w_do_write && w_do_read) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_xadac_elastic.sv
// Self-checking bench for xadac_elastic: a vector table on a Depth=4
// registered buffer, plus hand-written wrap, fall-through and reset sequences.
module tb_xadac_elastic;

  typedef logic [7:0] byte_t;

  typedef struct {
    logic  fl;
    logic  sv;
    byte_t sd;
    logic  mr;
    logic  emv;
    byte_t emd;
    logic  chk_md;
    logic  esr;
    int    ecnt;
    logic  eaf;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Instance A: Depth=4, registered.
  logic fl_a, sv_a, sr_a, mv_a, mr_a, af_a;
  byte_t sd_a, md_a;
  logic [2:0] cnt_a;
  // Instance B: Depth=3, registered (wrap-around).
  logic fl_b, sv_b, sr_b, mv_b, mr_b, af_b;
  byte_t sd_b, md_b;
  logic [1:0] cnt_b;
  // Instance C: Depth=4, fall-through.
  logic fl_c, sv_c, sr_c, mv_c, mr_c, af_c;
  byte_t sd_c, md_c;
  logic [2:0] cnt_c;

  xadac_elastic #(.DataT(byte_t), .Depth(4), .FallThrough(1'b0)) u_a (
    .clk(clk), .rstn(rstn), .flush(fl_a), .slv_data(sd_a), .slv_valid(sv_a),
    .slv_ready(sr_a), .mst_data(md_a), .mst_valid(mv_a), .mst_ready(mr_a),
    .count(cnt_a), .almost_full(af_a));

  xadac_elastic #(.DataT(byte_t), .Depth(3), .FallThrough(1'b0)) u_b (
    .clk(clk), .rstn(rstn), .flush(fl_b), .slv_data(sd_b), .slv_valid(sv_b),
    .slv_ready(sr_b), .mst_data(md_b), .mst_valid(mv_b), .mst_ready(mr_b),
    .count(cnt_b), .almost_full(af_b));

  xadac_elastic #(.DataT(byte_t), .Depth(4), .FallThrough(1'b1)) u_c (
    .clk(clk), .rstn(rstn), .flush(fl_c), .slv_data(sd_c), .slv_valid(sv_c),
    .slv_ready(sr_c), .mst_data(md_c), .mst_valid(mv_c), .mst_ready(mr_c),
    .count(cnt_c), .almost_full(af_c));

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic fl, input logic sv, input byte_t sd, input logic mr,
                              input logic emv, input byte_t emd, input logic chk_md,
                              input logic esr, input int ecnt, input logic eaf);
    vec_t v;
    v.fl = fl; v.sv = sv; v.sd = sd; v.mr = mr; v.emv = emv; v.emd = emd;
    v.chk_md = chk_md; v.esr = esr; v.ecnt = ecnt; v.eaf = eaf;
    vecs.push_back(v);
  endfunction

  task automatic drive_a(input logic fl, input logic sv, input byte_t sd, input logic mr);
    @(posedge clk); #1;
    fl_a = fl; sv_a = sv; sd_a = sd; mr_a = mr;
    @(negedge clk);
  endtask

  initial begin
    int sent, rcvd, exp_cnt;
    logic push_m, pop_m;

    rstn = 1'b0;
    {fl_a, sv_a, mr_a} = '0; sd_a = '0;
    {fl_b, sv_b, mr_b} = '0; sd_b = '0;
    {fl_c, sv_c, mr_c} = '0; sd_c = '0;

    // Reset phase.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_slv_ready", sr_a, 1'b0);
    check("rst_count", cnt_a, 0);
    check("rst_almost_full", af_a, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rel_slv_ready", sr_a, 1'b1);
    check("rel_mst_valid", mv_a, 1'b0);
    check("rel_c_mst_valid", mv_c, 1'b0);

    //   fl sv  sd     mr  emv emd    chk esr cnt af
    // Fill A1..A4 with the consumer stalled, then drain in order.
    add(0, 1, 8'hA1, 0,  0, 8'h00, 0,  1,  0, 0);
    add(0, 1, 8'hA2, 0,  1, 8'hA1, 1,  1,  1, 0);
    add(0, 1, 8'hA3, 0,  1, 8'hA1, 1,  1,  2, 0);
    add(0, 1, 8'hA4, 0,  1, 8'hA1, 1,  1,  3, 1);
    add(0, 1, 8'hB0, 0,  1, 8'hA1, 1,  0,  4, 1);
    add(0, 0, 8'h00, 1,  1, 8'hA1, 1,  0,  4, 1);
    add(0, 0, 8'h00, 1,  1, 8'hA2, 1,  1,  3, 1);
    add(0, 0, 8'h00, 1,  1, 8'hA3, 1,  1,  2, 0);
    add(0, 0, 8'h00, 1,  1, 8'hA4, 1,  1,  1, 0);
    add(0, 0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 0);
    // Full with pop and push offered together: pop only, push lands next cycle.
    add(0, 1, 8'hC1, 0,  0, 8'h00, 0,  1,  0, 0);
    add(0, 1, 8'hC2, 0,  1, 8'hC1, 1,  1,  1, 0);
    add(0, 1, 8'hC3, 0,  1, 8'hC1, 1,  1,  2, 0);
    add(0, 1, 8'hC4, 0,  1, 8'hC1, 1,  1,  3, 1);
    add(0, 1, 8'hC5, 1,  1, 8'hC1, 1,  0,  4, 1);
    add(0, 1, 8'hC5, 0,  1, 8'hC2, 1,  1,  3, 1);
    add(0, 0, 8'h00, 0,  1, 8'hC2, 1,  0,  4, 1);
    add(0, 0, 8'h00, 1,  1, 8'hC2, 1,  0,  4, 1);
    // Mid-occupancy push and pop together keep the count.
    add(0, 1, 8'hD1, 1,  1, 8'hC3, 1,  1,  3, 1);
    add(0, 0, 8'h00, 1,  1, 8'hC4, 1,  1,  3, 1);
    add(0, 0, 8'h00, 1,  1, 8'hC5, 1,  1,  2, 0);
    add(0, 0, 8'h00, 1,  1, 8'hD1, 1,  1,  1, 0);
    add(0, 0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 0);
    // Flush at count=2 with an upstream beat offered.
    add(0, 1, 8'hE1, 0,  0, 8'h00, 0,  1,  0, 0);
    add(0, 1, 8'hE2, 0,  1, 8'hE1, 1,  1,  1, 0);
    add(1, 1, 8'hE3, 1,  0, 8'h00, 0,  0,  2, 0);
    add(0, 1, 8'h77, 0,  0, 8'h00, 0,  1,  0, 0);
    add(0, 0, 8'h00, 1,  1, 8'h77, 1,  1,  1, 0);
    add(0, 0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 0);

    foreach (vecs[i]) begin
      drive_a(vecs[i].fl, vecs[i].sv, vecs[i].sd, vecs[i].mr);
      check($sformatf("v%0d_mst_valid", i), mv_a, vecs[i].emv);
      check($sformatf("v%0d_slv_ready", i), sr_a, vecs[i].esr);
      check($sformatf("v%0d_count", i), cnt_a, vecs[i].ecnt);
      check($sformatf("v%0d_almost_full", i), af_a, vecs[i].eaf);
      if (vecs[i].chk_md) check($sformatf("v%0d_mst_data", i), md_a, vecs[i].emd);
    end

    // Wrap-around on Depth=3: ten beats, consumer ready toggling each cycle.
    sent = 0; rcvd = 0; exp_cnt = 0;
    for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
      @(posedge clk); #1;
      sv_b = (sent < 10);
      sd_b = byte_t'(sent);
      mr_b = cyc[0];
      @(negedge clk);
      check("wrap_count", cnt_b, exp_cnt);
      check("wrap_slv_ready", sr_b, exp_cnt != 3);
      check("wrap_mst_valid", mv_b, exp_cnt != 0);
      push_m = sv_b && (exp_cnt != 3);
      pop_m  = mr_b && (exp_cnt != 0);
      if (pop_m) begin
        check("wrap_data", md_b, rcvd);
        rcvd++;
      end
      if (push_m) sent++;
      exp_cnt = exp_cnt + int'(push_m) - int'(pop_m);
    end
    check("wrap_all_received", rcvd, 10);
    @(posedge clk); #1;
    sv_b = 1'b0; mr_b = 1'b0;

    // Fall-through on an empty buffer.
    @(negedge clk);
    check("ft_idle_valid", mv_c, 1'b0);
    @(posedge clk); #1;
    sv_c = 1'b1; sd_c = 8'h55; mr_c = 1'b1;
    @(negedge clk);
    check("ft_bypass_valid", mv_c, 1'b1);
    check("ft_bypass_data", md_c, 8'h55);
    @(posedge clk); #1;
    mr_c = 1'b0;
    @(negedge clk);
    check("ft_bypass_count", cnt_c, 0);
    check("ft_stall_valid", mv_c, 1'b1);
    check("ft_stall_data", md_c, 8'h55);
    @(posedge clk); #1;
    sv_c = 1'b0; sd_c = 8'h00;
    @(negedge clk);
    check("ft_stored_count", cnt_c, 1);
    check("ft_stored_valid", mv_c, 1'b1);
    check("ft_stored_data", md_c, 8'h55);
    @(posedge clk); #1;
    mr_c = 1'b1;
    @(posedge clk); #1;
    mr_c = 1'b0;
    @(negedge clk);
    check("ft_drained_count", cnt_c, 0);

    // Reset with three beats stored; none may reappear.
    drive_a(0, 1, 8'hF1, 0);
    drive_a(0, 1, 8'hF2, 0);
    drive_a(0, 1, 8'hF3, 0);
    drive_a(0, 0, 8'h00, 0);
    check("pre_rst_count", cnt_a, 3);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_slv_ready", sr_a, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_count", cnt_a, 0);
    check("post_rst_mst_valid", mv_a, 1'b0);
    check("post_rst_slv_ready", sr_a, 1'b1);
    check("post_rst_almost_full", af_a, 1'b0);
    drive_a(0, 1, 8'h88, 1);
    check("post_rst_empty_valid", mv_a, 1'b0);
    drive_a(0, 0, 8'h00, 1);
    check("post_rst_first_valid", mv_a, 1'b1);
    check("post_rst_first_data", md_a, 8'h88);
    drive_a(0, 0, 8'h00, 0);
    check("post_rst_final_count", cnt_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
